// File: rtl/stopwatch_core_param.sv
// rtl/stopwatch_core_param.sv - parametrised BCD stopwatch/timer core with tick prescaler, pair adjust and expiry
// Optional lap freeze register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core_param #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int ADJ_DIV    = 50000000,
  parameter int SELW       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_pause,
  input  logic                    i_clear,
  input  logic                    i_down,
  input  logic                    i_adj,
  input  logic [SELW-1:0]         i_sel,
  input  logic                    i_lap,
  output logic [4*NUM_DIGITS-1:0] o_val,
  output logic                    o_running,
  output logic                    o_expired,
  output logic                    o_blink,
  output logic                    o_lap_active
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int NP = NUM_DIGITS/2;
  localparam int RW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ADJ_DIV);

  // Tens digit of every pair stops at 5, except the top pair which runs to 99.
  function automatic logic [3:0] dmax(input int i);
    return ((i % 2 == 1) && (i != NUM_DIGITS-1)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] max_val();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = dmax(i);
    return r;
  endfunction

  localparam logic [W-1:0] MAXV = max_val();

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == dmax(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = dmax(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Adjust increments one pair in isolation: it wraps but never carries upward.
  function automatic logic [W-1:0] pair_inc(input logic [W-1:0] v, input logic [SELW-1:0] s);
    logic [W-1:0] r;
    r = v;
    for (int p = 0; p < NP; p++) begin
      if (int'(s) == p) begin
        if (v[8*p +: 4] == 4'd9) begin
          r[8*p +: 4]     = 4'd0;
          r[8*p + 4 +: 4] = (v[8*p + 4 +: 4] == dmax(2*p+1)) ? 4'd0 : v[8*p + 4 +: 4] + 4'd1;
        end else begin
          r[8*p +: 4] = v[8*p +: 4] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0]  digits_q, digits_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [AW-1:0] adj_cnt_q, adj_cnt_d;
  logic          blink_q, blink_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          adj_wrap, tick;
`ifdef STOPWATCH_LAP_EN
  logic [W-1:0]  lap_q, lap_d;
  logic          lap_active_q, lap_active_d;
`else
  logic          unused_lap;
  assign unused_lap = i_lap;
`endif

  always_comb begin
    adj_wrap  = (adj_cnt_q == AW'(ADJ_DIV-1));
    tick      = running_q && (run_cnt_q == RW'(TICK_DIV-1));
    digits_d  = digits_q;
    run_cnt_d = run_cnt_q;
    adj_cnt_d = adj_wrap ? '0 : adj_cnt_q + AW'(1);
    blink_d   = blink_q ^ adj_wrap;
    running_d = running_q;
    expired_d = expired_q;
`ifdef STOPWATCH_LAP_EN
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
`endif
    if (i_clear) begin
      digits_d  = '0;
      run_cnt_d = '0;
      adj_cnt_d = '0;
      running_d = 1'b0;
      expired_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_active_d = 1'b0;
`endif
    end else if (i_adj) begin
      expired_d = 1'b0;
      if (adj_wrap) digits_d = pair_inc(digits_q, i_sel);
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (i_lap) begin
        if (!lap_active_q) begin
          lap_d        = digits_q;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
`endif
      if (running_q) run_cnt_d = tick ? '0 : run_cnt_q + RW'(1);
      if (tick) begin
        if (!i_down) begin
          if (digits_q == MAXV) begin
            running_d = 1'b0;
            expired_d = 1'b1;
          end else begin
            digits_d = bcd_inc(digits_q);
          end
        end else if (digits_q == '0) begin
          running_d = 1'b0;
          expired_d = 1'b1;
        end else begin
          digits_d = bcd_dec(digits_q);
          if (digits_q == W'(1)) begin
            running_d = 1'b0;
            expired_d = 1'b1;
          end
        end
      end else if (i_pause) begin
        if (running_q) begin
          running_d = 1'b0;
        end else if (!(i_down && (digits_q == '0))) begin
          running_d = 1'b1;
          expired_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      run_cnt_q <= '0;
      adj_cnt_q <= '0;
      blink_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      run_cnt_q <= run_cnt_d;
      adj_cnt_q <= adj_cnt_d;
      blink_q   <= blink_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else begin
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign o_val        = lap_active_q ? lap_q : digits_q;
  assign o_lap_active = lap_active_q;
`else
  assign o_val        = digits_q;
  assign o_lap_active = 1'b0;
`endif

  assign o_running = running_q;
  assign o_expired = expired_q;
  assign o_blink   = blink_q;
endmodule

// File: tb/tb_stopwatch_core_param.sv
// tb/tb_stopwatch_core_param.sv - self-checking bench for stopwatch_core_param against a seconds-count model
module tb_stopwatch_core_param;
  localparam int TD   = 4;
  localparam int AD   = 2;
  localparam int MAXS = 99*60 + 59;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_pause = 1'b0, i_clear = 1'b0, i_down = 1'b0, i_adj = 1'b0, i_lap = 1'b0;
  logic [1:0]  i_sel = 2'd0;
  logic [15:0] o_val;
  logic        o_running, o_expired, o_blink, o_lap_active;

  int checks = 0;
  int failures = 0;

  // Model state: value held as a plain count of seconds (MM*60+SS).
  int m_val, m_pre, m_adjc, m_lapval;
  bit m_run, m_exp, m_blink, m_lap;

  stopwatch_core_param #(.NUM_DIGITS(4), .TICK_DIV(TD), .ADJ_DIV(AD), .SELW(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_pause(i_pause), .i_clear(i_clear), .i_down(i_down),
    .i_adj(i_adj), .i_sel(i_sel), .i_lap(i_lap), .o_val(o_val), .o_running(o_running),
    .o_expired(o_expired), .o_blink(o_blink), .o_lap_active(o_lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int mm, ss;
    mm = v / 60;
    ss = v % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_val = 0; m_pre = 0; m_adjc = 0; m_lapval = 0;
    m_run = 0; m_exp = 0; m_blink = 0; m_lap = 0;
  endtask

  task automatic m_step(input bit p, input bit c, input bit l);
    bit wrap, tk;
    int mm, ss;
    wrap = (m_adjc == AD-1);
    m_adjc = wrap ? 0 : m_adjc + 1;
    if (wrap) m_blink = ~m_blink;
    if (c) begin
      m_val = 0; m_pre = 0; m_adjc = 0; m_run = 0; m_exp = 0; m_lap = 0;
    end else if (i_adj) begin
      m_exp = 0;
      if (wrap) begin
        mm = m_val / 60;
        ss = m_val % 60;
        if (i_sel == 2'd0) ss = (ss + 1) % 60;
        else if (i_sel == 2'd1) mm = (mm + 1) % 100;
        m_val = mm*60 + ss;
      end
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (l) begin
        if (!m_lap) begin m_lapval = m_val; m_lap = 1; end
        else m_lap = 0;
      end
`endif
      tk = m_run && (m_pre == TD-1);
      if (m_run) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (!i_down) begin
          if (m_val == MAXS) begin m_run = 0; m_exp = 1; end
          else m_val++;
        end else begin
          if (m_val > 0) m_val--;
          if (m_val == 0) begin m_run = 0; m_exp = 1; end
        end
      end else if (p) begin
        if (m_run) m_run = 0;
        else if (!(i_down && m_val == 0)) begin m_run = 1; m_exp = 0; end
      end
    end
  endtask

  task automatic cyc(input bit p, input bit c, input bit l);
    i_pause = p; i_clear = c; i_lap = l;
    m_step(p, c, l);
    @(posedge clk);
    #1;
    chk("val", 32'(o_val), 32'(m_lap ? to_bcd(m_lapval) : to_bcd(m_val)));
    chk("running", 32'(o_running), 32'(m_run));
    chk("expired", 32'(o_expired), 32'(m_exp));
    chk("blink", 32'(o_blink), 32'(m_blink));
    chk("lap_active", 32'(o_lap_active), 32'(m_lap));
    i_pause = 0; i_clear = 0; i_lap = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0);
  endtask

  // Bounded adjust of one pair until the model's pair value reaches target.
  task automatic adj_pair(input logic [1:0] s, input int target);
    int k;
    i_adj = 1; i_sel = s;
    k = 0;
    while (((s == 2'd0) ? (m_val % 60) : (m_val / 60)) != target && k < 400) begin
      cyc(0, 0, 0);
      k++;
    end
    if (k >= 400) begin
      checks++; failures++;
      $display("FAIL adjust_timeout observed=%0d expected=%0d", m_val, target);
    end
    i_adj = 0;
  endtask

  task automatic preload(input int mm, input int ss);
    cyc(0, 1, 0);
    adj_pair(2'd1, mm);
    adj_pair(2'd0, ss);
  endtask

  initial begin
    logic [31:0] r;
    int wraps;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_val", 32'(o_val), 32'h0);
    chk("reset_running", 32'(o_running), 32'h0);
    chk("reset_expired", 32'(o_expired), 32'h0);
    chk("reset_blink", 32'(o_blink), 32'h0);
    chk("reset_lap", 32'(o_lap_active), 32'h0);
    rst_n = 1;

    cyc(1, 0, 0);
    idle(40);
    chk("run10", 32'(o_val), 32'h0010);
    chk("run10_running", 32'(o_running), 32'h1);

    preload(0, 59);
    cyc(1, 0, 0);
    idle(4);
    chk("carry_minute", 32'(o_val), 32'h0100);

    preload(99, 59);
    cyc(1, 0, 0);
    idle(4);
    chk("max_hold", 32'(o_val), 32'h9959);
    chk("max_expired", 32'(o_expired), 32'h1);
    chk("max_stopped", 32'(o_running), 32'h0);

    preload(1, 0);
    i_down = 1;
    cyc(1, 0, 0);
    idle(4);
    chk("borrow_minute", 32'(o_val), 32'h0059);

    preload(0, 1);
    cyc(1, 0, 0);
    idle(4);
    chk("down_zero", 32'(o_val), 32'h0000);
    chk("down_expired", 32'(o_expired), 32'h1);
    cyc(1, 0, 0);
    idle(4);
    chk("down_zero_pause_ignored", 32'(o_running), 32'h0);
    i_down = 0;

    preload(0, 58);
    i_adj = 1; i_sel = 2'd0;
    wraps = 0;
    for (int k = 0; k < 20 && wraps < 3; k++) begin
      if (m_adjc == AD-1) wraps++;
      cyc(0, 0, 0);
    end
    chk("adj_wrap_no_carry", 32'(o_val), 32'h0001);
    i_sel = 2'd3;
    idle(6);
    chk("adj_sel_out_of_range", 32'(o_val), 32'h0001);
    i_adj = 0;

    cyc(1, 0, 0);
    idle(9);
    cyc(1, 1, 0);
    chk("clear_pause_val", 32'(o_val), 32'h0);
    chk("clear_pause_running", 32'(o_running), 32'h0);
    chk("clear_pause_expired", 32'(o_expired), 32'h0);

`ifdef STOPWATCH_LAP_EN
    cyc(1, 0, 0);
    idle(20);
    chk("lap_pre", 32'(o_val), 32'h0005);
    cyc(0, 0, 1);
    chk("lap_frozen", 32'(o_val), 32'h0005);
    for (int k = 0; k < 40 && m_val != 8; k++) cyc(0, 0, 0);
    chk("lap_still_frozen", 32'(o_val), 32'h0005);
    cyc(0, 0, 1);
    chk("lap_release", 32'(o_val), 32'h0008);
    chk("lap_release_flag", 32'(o_lap_active), 32'h0);
`endif

    cyc(0, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      if (r[5:0] == 6'd0) i_adj = ~i_adj;
      if (r[11:6] == 6'd0) i_down = ~i_down;
      i_sel = r[13:12];
      cyc(r[16:14] == 3'd0, r[22:17] == 6'd0, r[26:23] == 4'd0);
    end
    i_adj = 0; i_down = 0;

    cyc(0, 1, 0);
    cyc(1, 0, 0);
    idle(7);
    rst_n = 0;
    #1;
    chk("async_rst_val", 32'(o_val), 32'h0);
    chk("async_rst_running", 32'(o_running), 32'h0);
    chk("async_rst_expired", 32'(o_expired), 32'h0);
    chk("async_rst_blink", 32'(o_blink), 32'h0);
    chk("async_rst_lap", 32'(o_lap_active), 32'h0);
    m_reset();
    #1;
    rst_n = 1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
